shift_reg_seq: RTL and testbench
================================

Name: shift_reg_seq

Overview:
- Parametrised WIDTH-bit shift register with a built-in shift sequencer.
- Start launches an N-step shift burst in one of four modes. Busy and Done flags report progress.
- Used as the operand/accumulator register in the serial datapath (multiplier, serial logic unit).
- Replaces fixed-width registers that needed an external FSM to count shifts.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- CNT_W, $clog2(WIDTH+1), width of the shift-count input. It must hold the value WIDTH.

Ports:
- Clk  in  1  clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high reset.
- Load  in  1  parallel load of D; accepted in IDLE only.
- D  in  WIDTH  parallel load data.
- Start  in  1  begin a shift burst; accepted in IDLE only.
- Count  in  CNT_W  number of single-bit shifts in the burst; sampled with Start.
- Mode  in  2  shift mode, sampled with Start:
  - 00 logical right (Shift_In into MSB)
  - 01 arithmetic right (MSB replicated)
  - 10 left (Shift_In into LSB)
  - 11 rotate right
- Shift_In  in  1  serial input bit; sampled on every shift edge in modes 00 and 10.
- Data_Out  out  WIDTH  register contents.
- Shift_Out  out  1  next bit to leave the register. Combinational: Data_Out[WIDTH-1] if the latched mode is 10, else Data_Out[0].
- Busy  out  1  high while in SHIFT.
- Done  out  1  single-cycle pulse in DONE.

Behaviour:
- Reset (synchronous, highest priority, any state):
  - Data_Out = 0, state = IDLE, remaining count = 0, latched mode = 00.
  - Busy = 0, Done = 0, Shift_Out = 0.
  - Reset during a burst aborts it; no Done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If Load: Data_Out <= D and state stays IDLE. Load has priority over a simultaneous Start; that Start is dropped.
  - Else if Start and Count == 0: next state is DONE with no shift. Mode is still latched.
  - Else if Start: latch Count into rem and Mode into mode_q; next state SHIFT. No shift occurs on this edge.
- SHIFT:
  - On each edge, perform exactly one single-bit shift per mode_q and set rem <= rem - 1.
  - When rem == 1 on the edge, the last shift happens and next state is DONE.
  - Load and Start are ignored; D and Count are don't-care.
- DONE:
  - Done = 1 for exactly one cycle; next state is IDLE unconditionally.
  - Load and Start are ignored in this cycle.
- Latency: Start sampled at edge E0. Shifts occur at E1..EN. Done is high in the cycle after EN. Earliest next Start is accepted at EN+2.
- Count > WIDTH is legal and all N shifts are performed:
  - Arithmetic mode saturates to all sign bits.
  - Logical and left modes fill with the successive Shift_In values.
  - Rotate wraps modulo WIDTH.
- Data_Out holds its value in every cycle without a load or shift.
- Busy and Done are never high simultaneously.

Test Plan:
1. Reset, then Load D=8'hA5 -> Data_Out=8'hA5 next cycle, Busy=0, Done=0, Shift_Out=1.
2. Data_Out=8'h96, Start with Count=3, Mode=01 -> Busy high for 3 cycles with Data_Out 8'hCB, 8'hE5, 8'hF2. Done pulses once in the next cycle, then IDLE.
3. Data_Out=8'h81, Start with Count=8, Mode=11 -> after 8 shifts Data_Out=8'h81 again. Shift_Out sequence per edge is 1,0,0,0,0,0,0,1.
4. Data_Out=8'h01, Start with Count=2, Mode=10, Shift_In=1 on both edges -> Data_Out=8'h03 then 8'h07. Shift_Out tracks bit 7 (0).
5. Start with Count=0 -> no change to Data_Out, Busy stays 0, Done pulses in the next cycle.
6. Simultaneous cases:
   - Load=1 and Start=1 in IDLE -> D loaded, no burst.
   - Load during SHIFT -> ignored.
   - Reset asserted at the 2nd shift of a 5-shift burst -> Data_Out=0, state IDLE, no Done pulse.

Source files
------------

// File: rtl/shift_reg_seq.sv
// WIDTH-bit shift register with a built-in burst sequencer.
// Start launches Count single-bit shifts in one of four modes.
module shift_reg_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   input  logic             Start,
   input  logic [CNT_W-1:0] Count,
   input  logic [1:0]       Mode,
   input  logic             Shift_In,
   output logic [WIDTH-1:0] Data_Out,
   output logic             Shift_Out,
   output logic             Busy,
   output logic             Done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] M_LSR = 2'b00;
   localparam logic [1:0] M_ASR = 2'b01;
   localparam logic [1:0] M_LSL = 2'b10;
   localparam logic [1:0] M_ROR = 2'b11;

   state_t           state_q, state_n;
   logic [WIDTH-1:0] data_q, data_n;
   logic [CNT_W-1:0] rem_q, rem_n;
   logic [1:0]       mode_q, mode_n;

   function automatic logic [WIDTH-1:0] shifted(
      input logic [WIDTH-1:0] d,
      input logic [1:0]       m,
      input logic             si
   );
      logic [WIDTH-1:0] r;
      unique case (m)
         M_LSR:   r = {si, d[WIDTH-1:1]};
         M_ASR:   r = {d[WIDTH-1], d[WIDTH-1:1]};
         M_LSL:   r = {d[WIDTH-2:0], si};
         M_ROR:   r = {d[0], d[WIDTH-1:1]};
         default: r = d;
      endcase
      return r;
   endfunction

   always_comb begin
      state_n = state_q;
      data_n  = data_q;
      rem_n   = rem_q;
      mode_n  = mode_q;
      unique case (state_q)
         IDLE: begin
            if (Load) begin
               data_n = D;
            end else if (Start) begin
               mode_n  = Mode;
               rem_n   = Count;
               state_n = (Count == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            data_n = shifted(data_q, mode_q, Shift_In);
            rem_n  = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1))
               state_n = DONE;
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         data_q  <= '0;
         rem_q   <= '0;
         mode_q  <= M_LSR;
      end else begin
         state_q <= state_n;
         data_q  <= data_n;
         rem_q   <= rem_n;
         mode_q  <= mode_n;
      end
   end

   // Left shifts drain from the MSB end, every other mode from the LSB end.
   assign Shift_Out = (mode_q == M_LSL) ? data_q[WIDTH-1] : data_q[0];
   assign Data_Out  = data_q;
   assign Busy      = (state_q == SHIFT);
   assign Done      = (state_q == DONE);

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed bench for shift_reg_seq: a queue of expected per-cycle
// records is built at each Start and drained as the burst runs.
module tb_shift_reg_seq;

   logic       Clk = 1'b0;
   logic       Reset, Load, Start, Shift_In;
   logic [7:0] D;
   logic [3:0] Count;
   logic [1:0] Mode;
   logic [7:0] Data_Out;
   logic       Shift_Out, Busy, Done;

   typedef struct {
      logic [7:0] d;
      logic       b;
      logic       dn;
      logic       so;
   } rec_t;

   rec_t       q[$];
   int         n_pass = 0;
   int         n_total = 0;
   logic [7:0] mdl;
   logic [1:0] mdl_mode;

   shift_reg_seq #(.WIDTH(8)) dut (
      .Clk(Clk), .Reset(Reset), .Load(Load), .D(D),
      .Start(Start), .Count(Count), .Mode(Mode),
      .Shift_In(Shift_In), .Data_Out(Data_Out),
      .Shift_Out(Shift_Out), .Busy(Busy), .Done(Done)
   );

   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic so_of(input logic [7:0] d, input logic [1:0] m);
      return (m == 2'b10) ? d[7] : d[0];
   endfunction

   function automatic logic [7:0] mshift(input logic [7:0] d,
                                         input logic [1:0] m,
                                         input logic si);
      logic [8:0]  t;
      logic [15:0] dd;
      case (m)
         2'b00: begin t = {si, d}; return t[8:1]; end
         2'b01: return 8'($signed(d) >>> 1);
         2'b10: begin t = {d, si}; return t[7:0]; end
         default: begin dd = {d, d}; return dd[8:1]; end
      endcase
   endfunction

   task automatic chk_rec(input string tag, input rec_t r);
      chk({tag, ".data"}, Data_Out, r.d);
      chk({tag, ".busy"}, {7'd0, Busy}, {7'd0, r.b});
      chk({tag, ".done"}, {7'd0, Done}, {7'd0, r.dn});
      chk({tag, ".so"}, {7'd0, Shift_Out}, {7'd0, r.so});
   endtask

   task automatic do_load(input string tag, input logic [7:0] v);
      rec_t r;
      Load = 1'b1;
      D    = v;
      step();
      Load = 1'b0;
      D    = 8'($urandom);
      mdl  = v;
      r = '{d: mdl, b: 1'b0, dn: 1'b0, so: so_of(mdl, mdl_mode)};
      chk_rec(tag, r);
   endtask

   task automatic burst(input string tag, input int n, input logic [1:0] m,
                        input logic [15:0] pat, input bit jam,
                        input int abort_at);
      rec_t r;
      int   last;
      int   i;
      logic [7:0] d;
      q.delete();
      d = mdl;
      mdl_mode = m;
      last = (abort_at > 0) ? abort_at - 1 : n;
      q.push_back('{d: d, b: (n > 0), dn: (n == 0), so: so_of(d, m)});
      for (int k = 1; k <= last; k++) begin
         d = mshift(d, m, pat[k-1]);
         q.push_back('{d: d, b: (k < n), dn: (k == n), so: so_of(d, m)});
      end
      if (abort_at > 0) begin
         d = 8'h00;
         mdl_mode = 2'b00;
         q.push_back('{d: d, b: 1'b0, dn: 1'b0, so: 1'b0});
      end
      q.push_back('{d: d, b: 1'b0, dn: 1'b0, so: so_of(d, mdl_mode)});
      mdl = d;
      Start = 1'b1;
      Count = 4'(n);
      Mode  = m;
      step();
      Start = 1'b0;
      Count = 4'($urandom);
      Mode  = 2'($urandom);
      r = q.pop_front();
      chk_rec({tag, ".e0"}, r);
      i = 1;
      while (q.size() > 0 && i < 64) begin
         Shift_In = (i <= 16) ? pat[i-1] : 1'b0;
         Reset    = (abort_at == i);
         if (jam) begin
            Load  = 1'b1;
            D     = 8'hFF;
            Start = 1'b1;
         end
         step();
         Reset = 1'b0;
         r = q.pop_front();
         chk_rec($sformatf("%s.c%0d", tag, i), r);
         i++;
      end
      Load  = 1'b0;
      Start = 1'b0;
      if (q.size() > 0) begin
         n_total++;
         $error("FAIL %s.timeout observed=%0d expected=0", tag, q.size());
      end
   endtask

   initial begin
      rec_t r;
      Reset = 1'b1; Load = 1'b0; Start = 1'b0; Shift_In = 1'b0;
      D = 8'h00; Count = 4'd0; Mode = 2'b00;
      mdl = 8'h00; mdl_mode = 2'b00;
      step();
      step();
      Reset = 1'b0;
      r = '{d: 8'h00, b: 1'b0, dn: 1'b0, so: 1'b0};
      chk_rec("reset", r);

      do_load("load_a5", 8'hA5);

      do_load("load_96", 8'h96);
      burst("asr3", 3, 2'b01, 16'h0000, 1'b0, 0);

      do_load("load_81", 8'h81);
      burst("ror8", 8, 2'b11, 16'h0000, 1'b0, 0);

      do_load("load_01", 8'h01);
      burst("lsl2", 2, 2'b10, 16'h0003, 1'b0, 0);

      burst("cnt0", 0, 2'b00, 16'h0000, 1'b0, 0);

      Load = 1'b1; D = 8'h3C; Start = 1'b1; Count = 4'd4; Mode = 2'b01;
      step();
      Load = 1'b0; Start = 1'b0;
      mdl = 8'h3C;
      r = '{d: mdl, b: 1'b0, dn: 1'b0, so: so_of(mdl, mdl_mode)};
      chk_rec("ld_st", r);
      step();
      chk_rec("ld_st2", r);

      do_load("load_5a", 8'h5A);
      burst("lsr4_jam", 4, 2'b00, 16'h000A, 1'b1, 0);

      do_load("load_c3", 8'hC3);
      burst("abort", 5, 2'b01, 16'h0000, 1'b0, 2);

      do_load("load_80", 8'h80);
      burst("asr10", 10, 2'b01, 16'h0000, 1'b0, 0);

      do_load("load_00", 8'h00);
      burst("lsr10", 10, 2'b00, 16'h02D7, 1'b0, 0);

      do_load("load_b4", 8'hB4);
      burst("ror11", 11, 2'b11, 16'h0000, 1'b0, 0);

      do_load("load_e1", 8'hE1);
      burst("lsl9", 9, 2'b10, 16'h0135, 1'b0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
